pu_or1k_wb_mux_pipelined: RTL and testbench

PU_OR1K_WB_MUX_PIPELINED -- requirements
Module: pu_or1k_wb_mux_pipelined

---
 rtl/pu_or1k_pkg.sv | 11 +
 rtl/pu_or1k_onehot_mux.sv | 19 +
 rtl/pu_or1k_wb_mux_pipelined.sv | 146 ++++++++++++++
 tb/tb_pu_or1k_wb_mux_pipelined.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_or1k_pkg.sv
// Shared types and constants for the OR1K writeback result mux.
package pu_or1k_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  localparam logic [3:0] LATE_MASK_DEFAULT = 4'b0100;

endpackage

// File: rtl/pu_or1k_onehot_mux.sv
// Priority one-hot data mux: the lowest set select bit wins, and an all-zero select picks source 0.
module pu_or1k_onehot_mux #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32
) (
  input  logic [NUM_SRC*WIDTH-1:0] data_i,
  input  logic [NUM_SRC-1:0]       sel_i,
  output logic [WIDTH-1:0]         data_o
);

  // Scan from the top down so that the lowest set index is the last to assign.
  always_comb begin
    data_o = data_i[WIDTH-1:0];
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (sel_i[i]) data_o = data_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pu_or1k_wb_mux_pipelined.sv
// Writeback result mux with a stall-on-not-ready FSM. Late sources are muxed in the writeback cycle.
// Define PU_OR1K_WB_BYPASS_EN to expose bypass_valid_o/bypass_result_o for forwarding to decode.
//
// state | meaning
// IDLE  | accepting ops; a ready or late source writes back on the next cycle
// WAIT  | holding the latched op until its source asserts ready; upstream is stalled
module pu_or1k_wb_mux_pipelined
  import pu_or1k_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_SRC              = 4,
  parameter logic [NUM_SRC-1:0] LATE_MASK = NUM_SRC'(LATE_MASK_DEFAULT)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC*OPTION_OPERAND_WIDTH-1:0] src_result_i,
  input  logic [NUM_SRC-1:0]                      src_sel_i,
  input  logic [NUM_SRC-1:0]                      src_ready_i,
  input  logic                                    wb_valid_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]         rfd_adr_i,
  input  logic                                    rf_we_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]         rf_result_o,
  output logic                                    rf_we_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]         rf_adr_o,
`ifdef PU_OR1K_WB_BYPASS_EN
  output logic                                    bypass_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]         bypass_result_o,
`endif
  output logic                                    wb_stall_o
);

  wb_state_t                         state_q, state_d;
  logic [NUM_SRC-1:0]                sel_q, sel_d;
  logic [OPTION_RF_ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic                              we_pend_q, we_pend_d;
  logic [OPTION_OPERAND_WIDTH-1:0]   result_q, result_d;
  logic                              rf_we_q, rf_we_d;
  logic                              late_q, late_d;

  logic [NUM_SRC-1:0]                sel_norm;
  logic                              sel_found;
  logic [NUM_SRC-1:0]                reg_mux_sel;
  logic [OPTION_OPERAND_WIDTH-1:0]   reg_mux_out;
  logic [OPTION_OPERAND_WIDTH-1:0]   late_mux_out;
  logic                              wait_ready;

  // Reduce the incoming select to a true one-hot so that the ready and late tests agree with the data path.
  always_comb begin
    sel_norm  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel_i[i] && !sel_found) begin
        sel_norm[i] = 1'b1;
        sel_found   = 1'b1;
      end
    end
    if (!sel_found) sel_norm[0] = 1'b1;
  end

  assign reg_mux_sel = (state_q == IDLE) ? sel_norm : sel_q;
  assign wait_ready  = |(sel_q & src_ready_i);

  pu_or1k_onehot_mux #(
    .NUM_SRC (NUM_SRC),
    .WIDTH   (OPTION_OPERAND_WIDTH)
  ) u_reg_mux (
    .data_i (src_result_i),
    .sel_i  (reg_mux_sel),
    .data_o (reg_mux_out)
  );

  pu_or1k_onehot_mux #(
    .NUM_SRC (NUM_SRC),
    .WIDTH   (OPTION_OPERAND_WIDTH)
  ) u_late_mux (
    .data_i (src_result_i),
    .sel_i  (sel_q),
    .data_o (late_mux_out)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    we_pend_d = we_pend_q;
    result_d  = result_q;
    rf_we_d   = 1'b0;
    late_d    = late_q;
    case (state_q)
      IDLE: begin
        if (wb_valid_i) begin
          sel_d     = sel_norm;
          adr_d     = rfd_adr_i;
          we_pend_d = rf_we_i;
          late_d    = |(sel_norm & LATE_MASK);
          if (|(sel_norm & (src_ready_i | LATE_MASK))) begin
            result_d = reg_mux_out;
            rf_we_d  = rf_we_i;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_ready) begin
          result_d = reg_mux_out;
          rf_we_d  = we_pend_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      adr_q     <= '0;
      we_pend_q <= 1'b0;
      result_q  <= '0;
      rf_we_q   <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      we_pend_q <= we_pend_d;
      result_q  <= result_d;
      rf_we_q   <= rf_we_d;
      late_q    <= late_d;
    end
  end

  assign rf_result_o = late_q ? late_mux_out : result_q;
  assign rf_we_o     = rf_we_q;
  assign rf_adr_o    = adr_q;
  assign wb_stall_o  = (state_q == WAIT) && !wait_ready;

`ifdef PU_OR1K_WB_BYPASS_EN
  assign bypass_valid_o  = rf_we_o;
  assign bypass_result_o = rf_result_o;
`endif

endmodule

// File: tb/tb_pu_or1k_wb_mux_pipelined.sv
// Directed bench for pu_or1k_wb_mux_pipelined with a per-cycle reference model of the writeback rules.
module tb_pu_or1k_wb_mux_pipelined;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NS = 4;
  localparam logic [NS-1:0] LATE = 4'b0100;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*W-1:0] src_result_i;
  logic [NS-1:0]   src_sel_i;
  logic [NS-1:0]   src_ready_i;
  logic            wb_valid_i;
  logic [AW-1:0]   rfd_adr_i;
  logic            rf_we_i;
  logic [W-1:0]    rf_result_o;
  logic            rf_we_o;
  logic [AW-1:0]   rf_adr_o;
  logic            wb_stall_o;
`ifdef PU_OR1K_WB_BYPASS_EN
  logic            bypass_valid_o;
  logic [W-1:0]    bypass_result_o;
`endif

  pu_or1k_wb_mux_pipelined dut (
    .clk          (clk),
    .rst          (rst),
    .src_result_i (src_result_i),
    .src_sel_i    (src_sel_i),
    .src_ready_i  (src_ready_i),
    .wb_valid_i   (wb_valid_i),
    .rfd_adr_i    (rfd_adr_i),
    .rf_we_i      (rf_we_i),
    .rf_result_o  (rf_result_o),
    .rf_we_o      (rf_we_o),
    .rf_adr_o     (rf_adr_o),
`ifdef PU_OR1K_WB_BYPASS_EN
    .bypass_valid_o  (bypass_valid_o),
    .bypass_result_o (bypass_result_o),
`endif
    .wb_stall_o   (wb_stall_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [NS-1:0] sel);
    for (int i = 0; i < NS; i++) if (sel[i]) return i;
    return 0;
  endfunction

  function automatic logic [W-1:0] slice(input int i);
    return src_result_i[i*W +: W];
  endfunction

  // Reference model: one pending op at most; a completed op is visible for exactly one cycle.
  logic          m_busy, m_pwe, m_we, m_late;
  int            m_psrc, m_src;
  logic [AW-1:0] m_padr, m_adr;
  logic [W-1:0]  m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_we   <= 1'b0;
      m_late <= 1'b0;
    end else begin
      m_we <= 1'b0;
      if (m_busy) begin
        if (src_ready_i[m_psrc]) begin
          m_busy <= 1'b0;
          m_we   <= m_pwe;
          m_adr  <= m_padr;
          m_res  <= slice(m_psrc);
          m_late <= 1'b0;
        end
      end else if (wb_valid_i) begin
        if (src_ready_i[pick(src_sel_i)] || LATE[pick(src_sel_i)]) begin
          m_we   <= rf_we_i;
          m_adr  <= rfd_adr_i;
          m_res  <= slice(pick(src_sel_i));
          m_src  <= pick(src_sel_i);
          m_late <= LATE[pick(src_sel_i)];
        end else begin
          m_busy <= 1'b1;
          m_psrc <= pick(src_sel_i);
          m_pwe  <= rf_we_i;
          m_padr <= rfd_adr_i;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("cyc_stall", 32'(wb_stall_o), 32'(m_busy && !src_ready_i[m_psrc]));
      check("cyc_we", 32'(rf_we_o), 32'(m_we));
      if (m_we) begin
        check("cyc_adr", 32'(rf_adr_o), 32'(m_adr));
        check("cyc_res", rf_result_o, m_late ? slice(m_src) : m_res);
      end
`ifdef PU_OR1K_WB_BYPASS_EN
      check("cyc_byp_v", 32'(bypass_valid_o), 32'(rf_we_o));
      check("cyc_byp_d", bypass_result_o, rf_result_o);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    src_result_i[i*W +: W] = v;
  endtask

  int stall_cnt;

  initial begin
    rst = 1'b0;
    src_result_i = '0;
    src_sel_i = '0;
    src_ready_i = '0;
    wb_valid_i = 1'b0;
    rfd_adr_i = '0;
    rf_we_i = 1'b0;
    #2;
    check("rst_we", 32'(rf_we_o), 32'd0);
    check("rst_stall", 32'(wb_stall_o), 32'd0);
    check("rst_adr", 32'(rf_adr_o), 32'd0);
    check("rst_res", rf_result_o, 32'd0);
    step(); step();
    rst = 1'b1;
    chk_en = 1'b1;

    // ALU ready on acceptance
    set_slice(0, 32'h1234_5678);
    src_sel_i = 4'b0001; src_ready_i = 4'b0001; wb_valid_i = 1'b1; rfd_adr_i = 5'd3; rf_we_i = 1'b1;
    step();
    wb_valid_i = 1'b0; src_ready_i = '0;
    #1;
    check("alu_we", 32'(rf_we_o), 32'd1);
    check("alu_adr", 32'(rf_adr_o), 32'd3);
    check("alu_res", rf_result_o, 32'h1234_5678);

    // LSU not ready for three wait cycles; a competing op offered meanwhile is ignored
    set_slice(1, 32'hDEAD_BEEF);
    src_sel_i = 4'b0010; src_ready_i = 4'b0000; wb_valid_i = 1'b1; rfd_adr_i = 5'd5; rf_we_i = 1'b1;
    step();
    src_sel_i = 4'b0001; src_ready_i = 4'b0001; rfd_adr_i = 5'd6;
    stall_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (wb_stall_o) stall_cnt++;
      step();
    end
    wb_valid_i = 1'b0; src_ready_i = 4'b0011;
    #1;
    check("lsu_stall_drop", 32'(wb_stall_o), 32'd0);
    check("lsu_stall_cnt", 32'(stall_cnt), 32'd3);
    step();
    src_ready_i = '0;
    #1;
    check("lsu_we", 32'(rf_we_o), 32'd1);
    check("lsu_adr", 32'(rf_adr_o), 32'd5);
    check("lsu_res", rf_result_o, 32'hDEAD_BEEF);
    step();
    check("lsu_we_once", 32'(rf_we_o), 32'd0);

    // MUL is late: its data is taken in the writeback cycle
    set_slice(2, 32'h0000_FFFF);
    src_sel_i = 4'b0100; src_ready_i = 4'b0000; wb_valid_i = 1'b1; rfd_adr_i = 5'd7; rf_we_i = 1'b1;
    step();
    wb_valid_i = 1'b0;
    set_slice(2, 32'h0000_0042);
    #1;
    check("mul_we", 32'(rf_we_o), 32'd1);
    check("mul_res", rf_result_o, 32'h0000_0042);
    check("mul_stall", 32'(wb_stall_o), 32'd0);

    // Non-one-hot select: source 1 beats late source 2
    set_slice(1, 32'hAAAA_5555); set_slice(2, 32'h0000_0011);
    src_sel_i = 4'b0110; src_ready_i = 4'b0110; wb_valid_i = 1'b1; rfd_adr_i = 5'd9; rf_we_i = 1'b1;
    step();
    wb_valid_i = 1'b0;
    #1;
    check("prio_res", rf_result_o, 32'hAAAA_5555);
    check("prio_adr", 32'(rf_adr_o), 32'd9);

    // Op that does not write the register file
    src_sel_i = 4'b0001; src_ready_i = 4'b0001; wb_valid_i = 1'b1; rfd_adr_i = 5'd10; rf_we_i = 1'b0;
    step();
    wb_valid_i = 1'b0;
    #1;
    check("nowe_we", 32'(rf_we_o), 32'd0);

    // Back-to-back ready ops, one result per cycle
    rf_we_i = 1'b1; src_ready_i = 4'b1001; wb_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_sel_i = (i % 2 == 1) ? 4'b1000 : 4'b0001;
      set_slice((i % 2 == 1) ? 3 : 0, 32'h100 + 32'(i));
      rfd_adr_i = AW'(12 + i);
      step();
      check("b2b_we", 32'(rf_we_o), 32'd1);
      check("b2b_res", rf_result_o, 32'h100 + 32'(i));
    end
    wb_valid_i = 1'b0;
    #1;
    check("b2b_last_adr", 32'(rf_adr_o), 32'd15);

    // All-zero select falls back to source 0
    set_slice(0, 32'hCAFE_0000);
    src_sel_i = 4'b0000; src_ready_i = 4'b0001; wb_valid_i = 1'b1; rfd_adr_i = 5'd20;
    step();
    wb_valid_i = 1'b0;
    #1;
    check("zero_sel_res", rf_result_o, 32'hCAFE_0000);

    // Reset while waiting discards the pending op
    src_sel_i = 4'b0010; src_ready_i = 4'b0000; wb_valid_i = 1'b1; rfd_adr_i = 5'd21; rf_we_i = 1'b1;
    step();
    wb_valid_i = 1'b0;
    step();
    check("wait_stall", 32'(wb_stall_o), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_wait_stall", 32'(wb_stall_o), 32'd0);
    check("rst_wait_we", 32'(rf_we_o), 32'd0);
    src_ready_i = 4'b0010;
    step(); step();
    rst = 1'b1;
    step();
    check("post_rst_we", 32'(rf_we_o), 32'd0);
    check("post_rst_stall", 32'(wb_stall_o), 32'd0);
    step();
    check("post_rst_we2", 32'(rf_we_o), 32'd0);

    // Normal operation resumes after reset
    set_slice(0, 32'h0000_0077);
    src_sel_i = 4'b0001; src_ready_i = 4'b0001; wb_valid_i = 1'b1; rfd_adr_i = 5'd2;
    step();
    wb_valid_i = 1'b0;
    #1;
    check("resume_we", 32'(rf_we_o), 32'd1);
    check("resume_res", rf_result_o, 32'h0000_0077);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
